reg_file_mp: RTL and testbench
==============================

# reg_file_mp

Parametrised multi-port integer register file, successor to the single-cycle core's 2-read/1-write file. It serves a dual-issue or multi-cycle datapath: configurable width, depth and port counts, same-cycle write-to-read bypass, a per-register busy scoreboard, and a sequential clear engine so the storage array can map to RAM. It sits between decode (read and allocate) and writeback (write).

## Interface
Parameters:
- XLEN, 32, data width
- NREGS, 32, register count (power of two, ≥4); AW = log2(NREGS)
- NRD, 2, read ports
- NWR, 2, write ports
- BYPASS, 1, 1 = same-cycle write data forwarded to reads
- ZERO_REG, 1, 1 = entry 0 reads as 0 and ignores writes/allocs

Ports (clock and reset first):
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- clr  in  1  soft clear request; honoured only in RUN
- ready  out  1  1 = RUN state, file usable
- rs_addr  in  NRD*AW  read addresses; port k at [k*AW +: AW]
- rs_data  out  NRD*XLEN  read data; port k at [k*XLEN +: XLEN]
- rs_busy  out  NRD  1 = addressed register awaits a pending write
- we  in  NWR  write enables
- wa  in  NWR*AW  write addresses
- wd  in  NWR*XLEN  write data
- alloc_en  in  1  mark alloc_rd busy
- alloc_rd  in  AW  register to mark busy

## Operation
- Two states: CLEAR and RUN. Counter clr_idx (AW bits).
- rst=1: state←CLEAR, clr_idx←0, all busy←0, ready=0. Takes priority over every other input.
- CLEAR (rst=0): write 0 to entry clr_idx, clr_idx++; when clr_idx==NREGS-1 the entry is written and state←RUN. we, alloc_en, clr ignored; rs_data all 0; rs_busy all 0.
- RUN, clr=1: state←CLEAR, clr_idx←0, busy all←0; writes/allocs that cycle are dropped.
- Writes: each port k with we[k] writes wd[k] to entry wa[k]. Same address on several ports: highest port index wins. ZERO_REG=1: writes to address 0 discarded.
- Reads: combinational from array. ZERO_REG=1 and address 0 → 0. BYPASS=1 and address matches an enabled, non-discarded write this cycle → that write's data (highest index wins); otherwise the stored value.
- Scoreboard: any enabled write clears busy[wa]. alloc_en sets busy[alloc_rd]. A write and an alloc to the same register in one cycle: busy ends 1 (new producer wins). Writing a non-busy register is legal; busy stays 0. ZERO_REG=1: busy[0] constantly 0.
- rs_busy[k] = busy[rs_addr[k]] as registered. With BYPASS=1, it reads 0 if a same-cycle write to that address clears it and no same-cycle alloc targets it.

## Timing
- Read latency 0 (combinational). Write visible on reads the cycle after the edge, or same cycle when BYPASS=1.
- ready rises exactly NREGS rising edges after the first edge with rst=0. A clr in RUN gives ready=0 the next cycle, followed by NREGS cycles of CLEAR.
- rst asserted mid-CLEAR restarts the clear at index 0.
- Reset values: ready=0, rs_busy=0, rs_data=0.

## Structure
- Shared package reg_file_pkg: state encodings ST_CLEAR/ST_RUN, clog2 helper. No other typedefs.
- Sub-module reg_file_scoreboard: NREGS-bit busy vector with write-clear and alloc-set, and a combinational lookup per read port. The array, bypass mux and clear FSM stay in reg_file_mp.

## Test plan
- Reset release: rst high 3 cycles, then low → ready=0 for 32 cycles, ready=1 on cycle 32; every rs_data reads 0.
- Dual write conflict: we=2'b11, wa0=wa1=5, wd0=0xAAAA_AAAA, wd1=0x5555_5555 → same-cycle read of r5 (BYPASS=1) and next-cycle read both return 0x5555_5555.
- x0 protection: write 0xDEADBEEF to r0 and alloc r0 → rs_data=0 and rs_busy=0 for r0.
- Scoreboard: alloc r7, then 2 cycles later write r7=0x1234 together with alloc r7 → rs_busy stays 1. A later plain write to r7 → rs_busy=0, data=0x1234.
- Soft clear: r3=0x99 in RUN, assert clr for 1 cycle with a write to r4 → write dropped, ready low 32 cycles, afterwards r3=r4=0.
- BYPASS=0 build: write r9=0x42 → same-cycle read returns the old value 0, next cycle returns 0x42.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared definitions for the multi-port register file: clear/run state
// encoding and a constant-evaluable log2 helper for address widths.
package reg_file_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/reg_file_scoreboard.sv
// Per-register busy scoreboard: writes retire a pending producer, allocs mark
// a new one (alloc wins on a same-cycle collision), with a per-port lookup.
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int NREGS    = 32,
  parameter int AW       = 5,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic [NWR-1:0]    wr_en_i,
  input  logic [NWR*AW-1:0] wr_addr_i,
  input  logic              alloc_en_i,
  input  logic [AW-1:0]     alloc_addr_i,
  input  logic [NRD*AW-1:0] rd_addr_i,
  output logic [NRD-1:0]    rd_busy_o
);

  logic [NREGS-1:0] busy_q, busy_d;

  // Next busy vector: clear on write, then set on alloc, flush overrides all.
  always_comb begin
    busy_d = busy_q;
    for (int k = 0; k < NWR; k++) begin
      if (wr_en_i[k]) busy_d[wr_addr_i[k*AW +: AW]] = 1'b0;
    end
    if (alloc_en_i) busy_d[alloc_addr_i] = 1'b1;
    if (flush_i) busy_d = '0;
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  // Busy vector register.
  always_ff @(posedge clk) begin
    if (rst_i) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  for (genvar r = 0; r < NRD; r++) begin : g_lookup
    logic [AW-1:0] addr;
    logic          hit_wr;
    logic          hit_alloc;
    assign addr = rd_addr_i[r*AW +: AW];

    // Registered busy bit, forwarded as clear when a same-cycle write retires it.
    always_comb begin
      hit_wr    = 1'b0;
      hit_alloc = alloc_en_i && (alloc_addr_i == addr);
      for (int k = 0; k < NWR; k++) begin
        if (wr_en_i[k] && (wr_addr_i[k*AW +: AW] == addr)) hit_wr = 1'b1;
      end
      rd_busy_o[r] = busy_q[addr];
      if ((BYPASS != 0) && hit_wr && !hit_alloc) rd_busy_o[r] = 1'b0;
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with same-cycle write bypass, busy scoreboard and a
// one-entry-per-cycle clear engine so the array carries no reset and can map to RAM.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  output logic                ready,
  input  logic [NRD*AW-1:0]   rs_addr,
  output logic [NRD*XLEN-1:0] rs_data,
  output logic [NRD-1:0]      rs_busy,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   wa,
  input  logic [NWR*XLEN-1:0] wd,
  input  logic                alloc_en,
  input  logic [AW-1:0]       alloc_rd
);

  state_e          state_q, state_d;
  logic [AW-1:0]   clr_idx_q, clr_idx_d;
  logic [XLEN-1:0] mem_q [NREGS];

  logic            run;
  logic            op_ok;
  logic [NWR-1:0]  wr_eff;
  logic            alloc_eff;

  assign run   = (state_q == ST_RUN);
  assign ready = run;
  // Writes and allocs only act in RUN with no clear request and no reset.
  assign op_ok = run && !clr && !rst;

  // Qualify write ports: drop writes outside normal operation and to the zero register.
  always_comb begin
    wr_eff = '0;
    for (int k = 0; k < NWR; k++) begin
      wr_eff[k] = op_ok && we[k] &&
                  !((ZERO_REG != 0) && (wa[k*AW +: AW] == '0));
    end
  end

  assign alloc_eff = op_ok && alloc_en && !((ZERO_REG != 0) && (alloc_rd == '0));

  // Clear engine next state: sweep every index once, then run until a soft clear.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      ST_CLEAR: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == AW'(NREGS - 1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (clr) begin
          state_d   = ST_CLEAR;
          clr_idx_d = '0;
        end
      end
      default: begin
        state_d   = ST_CLEAR;
        clr_idx_d = '0;
      end
    endcase
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // Storage array: one zero write per cycle while clearing, else the write ports
  // in ascending order so the highest port index lands last on a collision.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      mem_q[clr_idx_q] <= '0;
    end else begin
      for (int k = 0; k < NWR; k++) begin
        if (wr_eff[k]) mem_q[wa[k*AW +: AW]] <= wd[k*XLEN +: XLEN];
      end
    end
  end

  for (genvar r = 0; r < NRD; r++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    assign addr = rs_addr[r*AW +: AW];

    // Read mux: stored value, overridden by the highest-index matching write.
    always_comb begin
      data = mem_q[addr];
      if (BYPASS != 0) begin
        for (int k = 0; k < NWR; k++) begin
          if (wr_eff[k] && (wa[k*AW +: AW] == addr)) data = wd[k*XLEN +: XLEN];
        end
      end
      if (!run || ((ZERO_REG != 0) && (addr == '0))) data = '0;
    end

    assign rs_data[r*XLEN +: XLEN] = data;
  end

  reg_file_scoreboard #(
    .NREGS    (NREGS),
    .AW       (AW),
    .NRD      (NRD),
    .NWR      (NWR),
    .BYPASS   (BYPASS),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk          (clk),
    .rst_i        (rst),
    .flush_i      (run && clr),
    .wr_en_i      (wr_eff),
    .wr_addr_i    (wa),
    .alloc_en_i   (alloc_eff),
    .alloc_addr_i (alloc_rd),
    .rd_addr_i    (rs_addr),
    .rd_busy_o    (rs_busy)
  );

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: a bypassing and a non-bypassing instance share the
// same stimulus and are compared with a register-file model kept here.
module tb_reg_file_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int NRD   = 2;
  localparam int NWR   = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                clr = 1'b0;
  logic [NRD*AW-1:0]   rs_addr = '0;
  logic [NWR-1:0]      we = '0;
  logic [NWR*AW-1:0]   wa = '0;
  logic [NWR*XLEN-1:0] wd = '0;
  logic                alloc_en = 1'b0;
  logic [AW-1:0]       alloc_rd = '0;

  logic                ready, ready_nb;
  logic [NRD*XLEN-1:0] rs_data, rs_data_nb;
  logic [NRD-1:0]      rs_busy, rs_busy_nb;

  int n_checks = 0;
  int n_errors = 0;

  // Model state
  logic [XLEN-1:0] m_mem [NREGS];
  bit              m_busy [NREGS];
  bit              m_ready = 1'b0;
  int              m_left = NREGS;

  always #5 clk = ~clk;

  reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR),
                .BYPASS(1), .ZERO_REG(1)) u_dut (
    .clk(clk), .rst(rst), .clr(clr), .ready(ready),
    .rs_addr(rs_addr), .rs_data(rs_data), .rs_busy(rs_busy),
    .we(we), .wa(wa), .wd(wd), .alloc_en(alloc_en), .alloc_rd(alloc_rd));

  reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR),
                .BYPASS(0), .ZERO_REG(1)) u_nb (
    .clk(clk), .rst(rst), .clr(clr), .ready(ready_nb),
    .rs_addr(rs_addr), .rs_data(rs_data_nb), .rs_busy(rs_busy_nb),
    .we(we), .wa(wa), .wd(wd), .alloc_en(alloc_en), .alloc_rd(alloc_rd));

  task automatic model_wipe();
    for (int i = 0; i < NREGS; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  // Advance one clock and apply the architectural effect of the inputs held at the edge.
  task automatic model_edge();
    logic [AW-1:0] a;
    @(posedge clk);
    if (rst) begin
      m_ready = 1'b0;
      m_left  = NREGS;
      model_wipe();
    end else if (!m_ready) begin
      m_left = m_left - 1;
      if (m_left == 0) m_ready = 1'b1;
    end else if (clr) begin
      m_ready = 1'b0;
      m_left  = NREGS;
      model_wipe();
    end else begin
      for (int k = 0; k < NWR; k++) begin
        a = wa[k*AW +: AW];
        if (we[k] && a != 0) m_mem[a] = wd[k*XLEN +: XLEN];
        if (we[k]) m_busy[a] = 1'b0;
      end
      if (alloc_en && alloc_rd != 0) m_busy[alloc_rd] = 1'b1;
    end
    #1;
  endtask

  function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] a, input bit byp);
    logic [XLEN-1:0] v;
    if (!m_ready || a == 0) return '0;
    v = m_mem[a];
    if (byp && !clr)
      for (int k = 0; k < NWR; k++)
        if (we[k] && wa[k*AW +: AW] == a) v = wd[k*XLEN +: XLEN];
    return v;
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a, input bit byp);
    bit hit;
    if (!m_ready || a == 0) return 1'b0;
    hit = 1'b0;
    if (byp && !clr)
      for (int k = 0; k < NWR; k++)
        if (we[k] && wa[k*AW +: AW] == a) hit = 1'b1;
    if (hit && !(alloc_en && alloc_rd == a)) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic idle_inputs();
    clr = 1'b0; we = '0; wa = '0; wd = '0; alloc_en = 1'b0; alloc_rd = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    for (int i = 0; i < 3; i++) model_edge();
    rst = 1'b0;
    for (int i = 0; i <= NREGS; i++) begin
      rs_addr = {AW'($urandom_range(NREGS - 1)), AW'($urandom_range(NREGS - 1))};
      @(negedge clk);
      n_checks++;
      if (ready !== (i == NREGS)) begin
        n_errors++;
        $display("FAIL reset_ready cycle %0d: got %b expected %b", i, ready, (i == NREGS));
      end
      if (i < NREGS) begin
        n_checks++;
        if (rs_data !== '0 || rs_busy !== '0) begin
          n_errors++;
          $display("FAIL reset_read cycle %0d: data %h busy %b expected 0", i, rs_data, rs_busy);
        end
      end
      if (i < NREGS) model_edge();
    end
  endtask

  task automatic test_dual_write();
    we = 2'b11;
    wa = {AW'(5), AW'(5)};
    wd = {32'h5555_5555, 32'hAAAA_AAAA};
    rs_addr = {AW'(5), AW'(5)};
    @(negedge clk);
    n_checks++;
    if (rs_data[0 +: XLEN] !== 32'h5555_5555) begin
      n_errors++;
      $display("FAIL dual_write_bypass: got %h expected 55555555", rs_data[0 +: XLEN]);
    end
    model_edge();
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if (rs_data[XLEN +: XLEN] !== 32'h5555_5555 || rs_data_nb[0 +: XLEN] !== 32'h5555_5555) begin
      n_errors++;
      $display("FAIL dual_write_stored: got %h / %h expected 55555555",
               rs_data[XLEN +: XLEN], rs_data_nb[0 +: XLEN]);
    end
    model_edge();
  endtask

  task automatic test_bypass0();
    we = 2'b01;
    wa = {AW'(0), AW'(9)};
    wd = {32'h0, 32'h42};
    rs_addr = {AW'(9), AW'(9)};
    @(negedge clk);
    n_checks++;
    if (rs_data_nb[0 +: XLEN] !== 32'h0) begin
      n_errors++;
      $display("FAIL nobypass_same_cycle: got %h expected 0", rs_data_nb[0 +: XLEN]);
    end
    n_checks++;
    if (rs_data[0 +: XLEN] !== 32'h42) begin
      n_errors++;
      $display("FAIL bypass_same_cycle: got %h expected 42", rs_data[0 +: XLEN]);
    end
    model_edge();
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if (rs_data_nb[XLEN +: XLEN] !== 32'h42) begin
      n_errors++;
      $display("FAIL nobypass_next_cycle: got %h expected 42", rs_data_nb[XLEN +: XLEN]);
    end
    model_edge();
  endtask

  task automatic test_x0();
    we = 2'b01;
    wa = '0;
    wd = {32'h0, 32'hDEAD_BEEF};
    alloc_en = 1'b1;
    alloc_rd = '0;
    rs_addr = '0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++;
      if (rs_data !== '0 || rs_busy !== '0) begin
        n_errors++;
        $display("FAIL x0_protect cycle %0d: data %h busy %b expected 0", c, rs_data, rs_busy);
      end
      model_edge();
      idle_inputs();
    end
  endtask

  task automatic test_scoreboard();
    rs_addr = {AW'(7), AW'(7)};
    alloc_en = 1'b1; alloc_rd = AW'(7);
    model_edge();
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if (rs_busy[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL sb_alloc: got %b expected 1", rs_busy[0]);
    end
    model_edge();
    we = 2'b01; wa = {AW'(0), AW'(7)}; wd = {32'h0, 32'h1234};
    alloc_en = 1'b1; alloc_rd = AW'(7);
    @(negedge clk);
    n_checks++;
    if (rs_busy[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL sb_write_alloc_same: got %b expected 1", rs_busy[0]);
    end
    model_edge();
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if (rs_busy[1] !== 1'b1 || rs_data[XLEN +: XLEN] !== 32'h1234) begin
      n_errors++;
      $display("FAIL sb_write_alloc_after: busy %b data %h expected 1 / 1234",
               rs_busy[1], rs_data[XLEN +: XLEN]);
    end
    model_edge();
    we = 2'b10; wa = {AW'(7), AW'(0)}; wd = {32'h1234, 32'h0};
    @(negedge clk);
    n_checks++;
    if (rs_busy[0] !== 1'b0 || rs_busy_nb[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL sb_retire_same: busy %b nobypass %b expected 0 / 1", rs_busy[0], rs_busy_nb[0]);
    end
    model_edge();
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if (rs_busy !== 2'b00 || rs_data[0 +: XLEN] !== 32'h1234) begin
      n_errors++;
      $display("FAIL sb_retire_after: busy %b data %h expected 00 / 1234", rs_busy, rs_data[0 +: XLEN]);
    end
    model_edge();
  endtask

  task automatic test_soft_clear();
    we = 2'b01; wa = {AW'(0), AW'(3)}; wd = {32'h0, 32'h99};
    model_edge();
    idle_inputs();
    rs_addr = {AW'(4), AW'(3)};
    @(negedge clk);
    n_checks++;
    if (rs_data[0 +: XLEN] !== 32'h99) begin
      n_errors++;
      $display("FAIL clr_setup: got %h expected 99", rs_data[0 +: XLEN]);
    end
    clr = 1'b1;
    we = 2'b01; wa = {AW'(0), AW'(4)}; wd = {32'h0, 32'h77};
    model_edge();
    idle_inputs();
    for (int i = 0; i < NREGS; i++) begin
      @(negedge clk);
      n_checks++;
      if (ready !== 1'b0) begin
        n_errors++;
        $display("FAIL clr_ready_low cycle %0d: got %b expected 0", i, ready);
      end
      model_edge();
    end
    @(negedge clk);
    n_checks++;
    if (ready !== 1'b1 || rs_data !== '0) begin
      n_errors++;
      $display("FAIL clr_done: ready %b data %h expected 1 / 0", ready, rs_data);
    end
    model_edge();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      clr = ($urandom_range(79) == 0);
      we  = NWR'($urandom);
      for (int k = 0; k < NWR; k++) begin
        wa[k*AW +: AW]     = AW'($urandom_range(7));
        wd[k*XLEN +: XLEN] = $urandom;
      end
      alloc_en = $urandom_range(1);
      alloc_rd = AW'($urandom_range(7));
      for (int r = 0; r < NRD; r++) rs_addr[r*AW +: AW] = AW'($urandom_range(7));
      @(negedge clk);
      n_checks++;
      if (ready !== m_ready || ready_nb !== m_ready) begin
        n_errors++;
        $display("FAIL rnd_ready step %0d: got %b/%b expected %b", n, ready, ready_nb, m_ready);
      end
      for (int r = 0; r < NRD; r++) begin
        n_checks++;
        if (rs_data[r*XLEN +: XLEN] !== exp_data(rs_addr[r*AW +: AW], 1'b1) ||
            rs_busy[r] !== exp_busy(rs_addr[r*AW +: AW], 1'b1)) begin
          n_errors++;
          $display("FAIL rnd_bypass step %0d port %0d: got %h/%b expected %h/%b", n, r,
                   rs_data[r*XLEN +: XLEN], rs_busy[r],
                   exp_data(rs_addr[r*AW +: AW], 1'b1), exp_busy(rs_addr[r*AW +: AW], 1'b1));
        end
        n_checks++;
        if (rs_data_nb[r*XLEN +: XLEN] !== exp_data(rs_addr[r*AW +: AW], 1'b0) ||
            rs_busy_nb[r] !== exp_busy(rs_addr[r*AW +: AW], 1'b0)) begin
          n_errors++;
          $display("FAIL rnd_nobypass step %0d port %0d: got %h/%b expected %h/%b", n, r,
                   rs_data_nb[r*XLEN +: XLEN], rs_busy_nb[r],
                   exp_data(rs_addr[r*AW +: AW], 1'b0), exp_busy(rs_addr[r*AW +: AW], 1'b0));
        end
      end
      model_edge();
    end
    idle_inputs();
  endtask

  task automatic test_rst_mid_clear();
    rst = 1'b1;
    model_edge();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) model_edge();
    rst = 1'b1;
    model_edge();
    rst = 1'b0;
    for (int i = 0; i <= NREGS; i++) begin
      @(negedge clk);
      n_checks++;
      if (ready !== (i == NREGS)) begin
        n_errors++;
        $display("FAIL rst_mid_clear cycle %0d: got %b expected %b", i, ready, (i == NREGS));
      end
      if (i < NREGS) model_edge();
    end
  endtask

  initial begin
    model_wipe();
    test_reset();
    test_dual_write();
    test_bypass0();
    test_x0();
    test_scoreboard();
    test_soft_clear();
    test_random();
    test_rst_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
